// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave controller: FSM states, R/W bit values
// and the all-ones direction value that parks the memory between transfers.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_LOAD,
    RD_BYTE,
    RD_ACK,
    WAIT_STOP
  } i2c_state_e;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam int MAX_ADDRESSLENGTH = 16;
  localparam logic [MAX_ADDRESSLENGTH-1:0] IDLE_ADDRESS = '1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings raw SCL/SDA into the Clk domain and turns them into single-cycle
// SCL edge strobes and START/STOP strobes.
module i2c_bus_sync (
  input  logic Clk,
  input  logic nReset,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  // [0] first sync stage, [1] synchronized level, [2] previous synchronized level
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge Clk) begin
    // NOTE: reset to the idle-bus level (high) so leaving reset never looks like an edge.
    if (!nReset) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  assign sda_o      = sda_q[1];
  assign scl_rise_o = scl_q[1] & ~scl_q[2];
  assign scl_fall_o = ~scl_q[1] & scl_q[2];
  assign start_o    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop_o     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/i2c_slave_control.sv
// Bit-level I2C slave: decodes address/R-W, shifts data bytes, drives ACK and
// read data on open-drain SDA, and pulses the byte memory once per bus byte.
module i2c_slave_control
  import i2c_pkg::*;
#(
  parameter int ADDRESSLENGTH = 7,
  parameter int SDA_HOLD      = 2
) (
  input  logic                     Clk,
  input  logic                     nReset,
  input  logic                     SclIn,
  input  logic                     SdaIn,
  output logic                     SdaDriveLow,
  output logic                     MemEnable,
  output logic                     MemRorW,
  output logic [ADDRESSLENGTH-1:0] MemDirection,
  output logic [7:0]               MemInput,
  input  logic [7:0]               MemOutput,
  input  logic                     MemAddressFound,
  output logic                     Busy
);

  localparam int RXW = (ADDRESSLENGTH + 1 > 8) ? ADDRESSLENGTH + 1 : 8;
  localparam int CW  = $clog2(RXW + 1);
  localparam int HW  = $clog2(SDA_HOLD + 1);
  localparam logic [CW-1:0] ADDR_BITS = CW'(ADDRESSLENGTH + 1);
  localparam logic [CW-1:0] DATA_BITS = CW'(8);
  localparam logic [ADDRESSLENGTH-1:0] DIR_IDLE = IDLE_ADDRESS[ADDRESSLENGTH-1:0];

  logic sda_s, scl_rise, scl_fall, start, stop;

  i2c_bus_sync u_sync (
    .Clk        (Clk),
    .nReset     (nReset),
    .scl_i      (SclIn),
    .sda_i      (SdaIn),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start),
    .stop_o     (stop)
  );

  i2c_state_e               state_q, state_d;
  logic [RXW-2:0]           rx_q, rx_d;
  logic [7:0]               tx_q, tx_d;
  logic [CW-1:0]            bit_q, bit_d;
  logic [1:0]               step_q, step_d;
  logic                     ack_q, ack_d;
  logic                     rw_q, rw_d;
  logic [HW-1:0]            hold_q, hold_d;
  logic                     drive_q, drive_d;
  logic                     en_q, en_d;
  logic                     rorw_q, rorw_d;
  logic [ADDRESSLENGTH-1:0] dir_q, dir_d;
  logic [7:0]               din_q, din_d;
  logic                     busy_q, busy_d;

  logic [RXW-1:0] rx_shift;
  logic [CW-1:0]  bit_inc;
  logic           drive_upd;

  assign rx_shift  = {rx_q, sda_s};
  assign bit_inc   = bit_q + CW'(1);
  assign drive_upd = (hold_q == HW'(1));

  always_comb begin
    // NOTE: every _d starts from its register so no path through this block can infer a latch.
    state_d = state_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    bit_d   = bit_q;
    step_d  = step_q;
    ack_d   = ack_q;
    rw_d    = rw_q;
    hold_d  = hold_q;
    drive_d = drive_q;
    en_d    = 1'b0;
    rorw_d  = rorw_q;
    dir_d   = dir_q;
    din_d   = din_q;
    busy_d  = busy_q;

    if (scl_fall) begin
      hold_d = HW'(SDA_HOLD);
    end else if (hold_q != '0) begin
      hold_d = hold_q - HW'(1);
    end

    unique case (state_q)
      IDLE: ;

      ADDR: begin
        if (step_q == 2'd0) begin
          if (scl_rise) begin
            rx_d  = rx_shift[RXW-2:0];
            bit_d = bit_inc;
            if (bit_inc == ADDR_BITS) begin
              dir_d  = rx_shift[ADDRESSLENGTH:1];
              rw_d   = rx_shift[0];
              bit_d  = '0;
              step_d = 2'd1;
            end
          end
        end else if (step_q == 2'd1) begin
          step_d = 2'd2;
        end else begin
          step_d = 2'd0;
          if (MemAddressFound) begin
            state_d = ADDR_ACK;
            busy_d  = 1'b1;
          end else begin
            state_d = WAIT_STOP;
          end
        end
      end

      ADDR_ACK, WR_ACK: begin
        if (drive_upd && !ack_q) begin
          drive_d = 1'b1;
          ack_d   = 1'b1;
        end else if (scl_fall && ack_q) begin
          ack_d = 1'b0;
          bit_d = '0;
          if (state_q == ADDR_ACK && rw_q == RW_READ) begin
            state_d = RD_LOAD;
            rorw_d  = 1'b0;
            step_d  = 2'd0;
          end else begin
            state_d = WR_BYTE;
          end
        end
      end

      WR_BYTE: begin
        if (drive_upd) drive_d = 1'b0;
        if (step_q == 2'd1) begin
          en_d    = 1'b1;
          step_d  = 2'd0;
          state_d = WR_ACK;
        end else if (scl_rise) begin
          rx_d  = rx_shift[RXW-2:0];
          bit_d = bit_inc;
          if (bit_inc == DATA_BITS) begin
            din_d  = rx_shift[7:0];
            rorw_d = 1'b1;
            bit_d  = '0;
            step_d = 2'd1;
          end
        end
      end

      RD_LOAD: begin
        if (drive_upd) drive_d = 1'b0;
        unique case (step_q)
          2'd0:    begin en_d = 1'b1; step_d = 2'd1; end
          2'd1:    step_d = 2'd2;
          default: begin
            tx_d    = MemOutput;
            bit_d   = '0;
            step_d  = 2'd0;
            state_d = RD_BYTE;
            // Hold point already reached: present bit 7 now rather than wait a phase.
            if (hold_q <= HW'(1)) drive_d = ~MemOutput[7];
          end
        endcase
      end

      RD_BYTE: begin
        if (drive_upd) drive_d = ~tx_q[7];
        if (scl_fall) begin
          if (bit_q == CW'(7)) begin
            state_d = RD_ACK;
            bit_d   = '0;
          end else begin
            tx_d  = {tx_q[6:0], 1'b0};
            bit_d = bit_inc;
          end
        end
      end

      RD_ACK: begin
        if (drive_upd) drive_d = 1'b0;
        if (scl_rise) begin
          if (!sda_s) ack_d = 1'b1;
          else        state_d = WAIT_STOP;
        end else if (scl_fall && ack_q) begin
          ack_d   = 1'b0;
          state_d = RD_LOAD;
          rorw_d  = 1'b0;
          step_d  = 2'd0;
        end
      end

      WAIT_STOP: drive_d = 1'b0;

      default: state_d = IDLE;
    endcase

    // Bus conditions abort whatever byte is in flight.
    if (start || stop) begin
      state_d = start ? ADDR : IDLE;
      drive_d = 1'b0;
      busy_d  = 1'b0;
      dir_d   = DIR_IDLE;
      en_d    = 1'b0;
      bit_d   = '0;
      step_d  = 2'd0;
      ack_d   = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments keep every register sampling the pre-edge values.
    if (!nReset) begin
      state_q <= IDLE;
      rx_q    <= '0;
      tx_q    <= '0;
      bit_q   <= '0;
      step_q  <= 2'd0;
      ack_q   <= 1'b0;
      rw_q    <= RW_WRITE;
      hold_q  <= '0;
      drive_q <= 1'b0;
      en_q    <= 1'b0;
      rorw_q  <= 1'b0;
      dir_q   <= DIR_IDLE;
      din_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      bit_q   <= bit_d;
      step_q  <= step_d;
      ack_q   <= ack_d;
      rw_q    <= rw_d;
      hold_q  <= hold_d;
      drive_q <= drive_d;
      en_q    <= en_d;
      rorw_q  <= rorw_d;
      dir_q   <= dir_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
    end
  end

  assign SdaDriveLow  = drive_q;
  assign MemEnable    = en_q;
  assign MemRorW      = rorw_q;
  assign MemDirection = dir_q;
  assign MemInput     = din_q;
  assign Busy         = busy_q;

endmodule

// File: tb/tb_i2c_slave_control.sv
// Bus-master bench for i2c_slave_control with a small byte memory peer; a
// scoreboard checks every memory Enable pulse, the master checks bus replies.
module tb_i2c_slave_control;

  localparam int AL       = 7;
  localparam int SDA_HOLD = 2;
  localparam int NBYTES   = 2;
  localparam int Q        = 10;
  localparam logic [AL-1:0] ADDRESS_LIST = 7'h48;
  localparam logic [AL-1:0] DIR_PARKED   = 7'h7F;

  typedef struct {
    logic       rorw;
    logic [7:0] data;
  } mem_ev_t;
  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  logic          sda_drive_low, mem_enable, mem_rorw, mem_found, busy;
  logic [AL-1:0] mem_direction;
  logic [7:0]    mem_input, mem_output;
  wire           sda_bus = sda_m & ~sda_drive_low;

  int checks = 0;
  int failures = 0;

  mem_ev_t    exp_q[$];
  logic [7:0] ref_mem [NBYTES];

  always #5 clk = ~clk;

  i2c_slave_control #(.ADDRESSLENGTH(AL), .SDA_HOLD(SDA_HOLD)) dut (
    .Clk             (clk),
    .nReset          (n_reset),
    .SclIn           (scl_m),
    .SdaIn           (sda_bus),
    .SdaDriveLow     (sda_drive_low),
    .MemEnable       (mem_enable),
    .MemRorW         (mem_rorw),
    .MemDirection    (mem_direction),
    .MemInput        (mem_input),
    .MemOutput       (mem_output),
    .MemAddressFound (mem_found),
    .Busy            (busy)
  );

  // Peer memory: byte counter restarts whenever the direction changes, wraps at NBYTES.
  logic [7:0]    env_mem [NBYTES];
  int            env_ptr = 0;
  logic [AL-1:0] env_dir_q = DIR_PARKED;

  assign mem_found = (mem_direction == ADDRESS_LIST);

  initial begin
    for (int i = 0; i < NBYTES; i++) begin
      env_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    mem_output = 8'h00;
  end

  always @(posedge clk) begin
    env_dir_q <= mem_direction;
    if (mem_direction != env_dir_q) env_ptr <= 0;
    if (mem_enable === 1'b1) begin
      if (mem_rorw) env_mem[env_ptr] <= mem_input;
      else          mem_output <= env_mem[env_ptr];
      env_ptr <= (env_ptr + 1) % NBYTES;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: each Enable pulse consumes the oldest expected memory access.
  logic prev_en = 1'b0;
  logic prev_rorw = 1'b0;
  always @(negedge clk) begin
    if (mem_enable === 1'b1) begin
      check("enable_not_back_to_back", {31'd0, prev_en}, 32'd0);
      check("rorw_stable_before_enable", {31'd0, prev_rorw}, {31'd0, mem_rorw});
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_enable actual=rorw%0b,data0x%0h required=no_pulse", mem_rorw, mem_input);
      end else begin
        mem_ev_t ev;
        ev = exp_q.pop_front();
        check("enable_rorw", {31'd0, mem_rorw}, {31'd0, ev.rorw});
        if (ev.rorw) check("enable_write_data", {24'd0, mem_input}, {24'd0, ev.data});
      end
    end
    prev_en   = (mem_enable === 1'b1);
    prev_rorw = mem_rorw;
  end

  initial begin
    #800000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input logic b, output logic seen);
    sda_m = b;
    wait_clks(Q);
    scl_m = 1'b1;
    wait_clks(Q);
    seen = sda_bus;
    wait_clks(Q);
    scl_m = 1'b0;
    wait_clks(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    sda_m = 1'b0; wait_clks(Q);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    sda_m = 1'b1; wait_clks(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic master_ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      b[i] = s;
    end
    clock_bit(~master_ack, s);
  endtask

  task automatic check_parked();
    check("busy_after_stop", {31'd0, busy}, 32'd0);
    check("direction_parked", {25'd0, mem_direction}, {25'd0, DIR_PARKED});
    check("sda_released", {31'd0, sda_drive_low}, 32'd0);
    check("all_pulses_seen", exp_q.size(), 32'd0);
  endtask

  task automatic write_txn(input byte_q_t data);
    logic ack;
    i2c_start();
    send_byte({ADDRESS_LIST, 1'b0}, ack);
    check("wr_addr_ack", {31'd0, ack}, 32'd1);
    check("wr_busy", {31'd0, busy}, 32'd1);
    check("wr_direction", {25'd0, mem_direction}, {25'd0, ADDRESS_LIST});
    for (int i = 0; i < data.size(); i++) begin
      exp_q.push_back('{1'b1, data[i]});
      send_byte(data[i], ack);
      check("wr_data_ack", {31'd0, ack}, 32'd1);
      ref_mem[i % NBYTES] = data[i];
    end
    i2c_stop();
    wait_clks(Q);
    check_parked();
  endtask

  task automatic read_txn(input int n);
    logic       ack;
    logic [7:0] b;
    i2c_start();
    for (int i = 0; i < n; i++) exp_q.push_back('{1'b0, 8'h00});
    send_byte({ADDRESS_LIST, 1'b1}, ack);
    check("rd_addr_ack", {31'd0, ack}, 32'd1);
    check("rd_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < n; i++) begin
      recv_byte(i != n - 1, b);
      check("rd_data", {24'd0, b}, {24'd0, ref_mem[i % NBYTES]});
    end
    check("rd_busy_until_stop", {31'd0, busy}, 32'd1);
    i2c_stop();
    wait_clks(Q);
    check_parked();
  endtask

  initial begin
    byte_q_t d;
    logic    ack, s;

    // Reset with the bus wiggling.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      scl_m = 1'($urandom);
      sda_m = 1'($urandom);
    end
    check("rst_sda", {31'd0, sda_drive_low}, 32'd0);
    check("rst_enable", {31'd0, mem_enable}, 32'd0);
    check("rst_rorw", {31'd0, mem_rorw}, 32'd0);
    check("rst_direction", {25'd0, mem_direction}, {25'd0, DIR_PARKED});
    check("rst_input", {24'd0, mem_input}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    wait_clks(2);
    n_reset = 1'b1;
    wait_clks(Q);
    check("idle_direction", {25'd0, mem_direction}, {25'd0, DIR_PARKED});

    // Matched write of two bytes.
    d = '{8'hA5, 8'h3C};
    write_txn(d);

    // Address mismatch: no ACK, nothing stored, stays quiet until STOP.
    i2c_start();
    send_byte({7'h49, 1'b0}, ack);
    check("mismatch_nack", {31'd0, ack}, 32'd0);
    check("mismatch_busy", {31'd0, busy}, 32'd0);
    send_byte(8'h00, ack);
    check("mismatch_data_nack", {31'd0, ack}, 32'd0);
    i2c_stop();
    wait_clks(Q);
    check_parked();

    // Read both bytes back, NACK the last.
    read_txn(2);

    // Abort a write mid-byte with a repeated START into a read.
    i2c_start();
    send_byte({ADDRESS_LIST, 1'b0}, ack);
    check("abort_addr_ack", {31'd0, ack}, 32'd1);
    for (int i = 0; i < 4; i++) clock_bit(1'($urandom), s);
    read_txn(1);

    // Three bytes into a two-byte memory wrap onto byte 0.
    d = '{8'h11, 8'h22, 8'h33};
    write_txn(d);
    check("wrap_mem0", {24'd0, env_mem[0]}, {24'd0, ref_mem[0]});
    check("wrap_mem1", {24'd0, env_mem[1]}, {24'd0, ref_mem[1]});
    read_txn(2);

    // Random write/read rounds.
    for (int r = 0; r < 4; r++) begin
      d.delete();
      for (int i = 0; i < int'($urandom_range(1, 4)); i++) d.push_back(8'($urandom));
      write_txn(d);
      read_txn(int'($urandom_range(1, 3)));
    end

    wait_clks(Q);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
